alarm_tone_gen: RTL and testbench

- Drives the GPIO pin with an audible beep pattern when the timer reaches a phase boundary (work/break expiry). It is the output-side counterpart of the input debouncers.
- Accepts a one-cycle request pulse plus a beep count. Emits that many square-wave tone bursts separated by silent gaps, then reports completion.
- Sits between timer_engine (source of the trigger and cancel pulses) and the top-level GPIO output.

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/tone_divider.sv | 55 +++++
 rtl/alarm_tone_gen.sv | 120 ++++++++++++
 tb/tb_alarm_tone_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and default timing constants for alarm_tone_gen
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Default cycle counts for a 100 MHz clock.
   localparam int DEF_TONE_HALF_CYC = 25000;     // 2 kHz tone
   localparam int DEF_BEEP_CYC      = 20000000;  // 200 ms burst
   localparam int DEF_GAP_CYC       = 10000000;  // 100 ms silence

   // Duration counter width; must hold max(BEEP_CYC, GAP_CYC).
   localparam int DEF_CNT_W         = 32;

   localparam int NUM_BEEPS_W       = 4;

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period square-wave generator for the alarm tone
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the divider; when low the output and counter are held at 0
//   clr        : restart the wave; the next output cycle is the first high half-period
//   sq_out     : registered square wave, high for the first HALF_CYC cycles after clr
module tone_divider
   import alarm_pkg::*;
#(
   parameter int HALF_CYC = DEF_TONE_HALF_CYC,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic sq_out
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sq_q, sq_d;

   always_comb begin
      cnt_d = cnt_q;
      sq_d  = sq_q;
      if (!en) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (clr) begin
         cnt_d = '0;
         sq_d  = 1'b1;
      end else if (cnt_q == HALF_LAST) begin
         cnt_d = '0;
         sq_d  = ~sq_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sq_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sq_q  <= sq_d;
      end
   end

   assign sq_out = sq_q;

endmodule

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - beep pattern generator driving the alarm GPIO
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   trigger    : one-cycle request; accepted only in IDLE with num_beeps != 0
//   cancel     : one-cycle abort; wins over a simultaneous trigger
//   num_beeps  : number of tone bursts, sampled on an accepted trigger
//   tone_out   : registered square-wave drive, 0 outside bursts
//   busy       : registered, high while a pattern runs
//   done       : registered one-cycle pulse in the first IDLE cycle after normal completion
module alarm_tone_gen
   import alarm_pkg::*;
#(
   parameter int TONE_HALF_CYC = DEF_TONE_HALF_CYC,
   parameter int BEEP_CYC      = DEF_BEEP_CYC,
   parameter int GAP_CYC       = DEF_GAP_CYC,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   trigger,
   input  logic                   cancel,
   input  logic [NUM_BEEPS_W-1:0] num_beeps,
   output logic                   tone_out,
   output logic                   busy,
   output logic                   done
);

   localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   state_t                 state_q, state_d;
   logic [NUM_BEEPS_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]       dur_q, dur_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   div_en, div_clr;
   logic                   tone_sq;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (trigger && !cancel && (num_beeps != '0)) begin
               state_d = ST_TONE;
               rem_d   = num_beeps;
            end
         end
         ST_TONE: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else if (dur_q == BEEP_LAST) begin
               if (rem_q > NUM_BEEPS_W'(1)) begin
                  rem_d   = rem_q - NUM_BEEPS_W'(1);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else if (dur_q == GAP_LAST) begin
               state_d = ST_TONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Duration restarts on every state change so each burst/gap counts from 0.
      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         dur_d = '0;
      end else begin
         dur_d = dur_q + CNT_W'(1);
      end

      busy_d = (state_d != ST_IDLE);

      // The divider is driven from the next state so its registered output
      // lines up with the registered state: high in the first TONE cycle.
      div_en  = (state_d == ST_TONE);
      div_clr = div_en && (state_q != ST_TONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         dur_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dur_q   <= dur_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   tone_divider #(
      .HALF_CYC (TONE_HALF_CYC),
      .CNT_W    (CNT_W)
   ) u_tone_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (div_en),
      .clr    (div_clr),
      .sq_out (tone_sq)
   );

   assign tone_out = tone_sq;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// tb/tb_alarm_tone_gen.sv - self-checking bench for alarm_tone_gen
module tb_alarm_tone_gen;

   localparam int HALF = 2;
   localparam int BEEP = 8;
   localparam int GAP  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trigger;
   logic       cancel;
   logic [3:0] num_beeps;
   logic       tone_out;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] exp_q[$];

   alarm_tone_gen #(
      .TONE_HALF_CYC (HALF),
      .BEEP_CYC      (BEEP),
      .GAP_CYC       (GAP),
      .CNT_W         (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .cancel    (cancel),
      .num_beeps (num_beeps),
      .tone_out  (tone_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Expected {tone_out, busy, done} in cycle c after a trigger at cycle 0.
   function automatic logic [2:0] model(int c, int nb, int cc);
      int total;
      int pos;
      if (nb == 0 || c == 0) return 3'b000;
      if (cc >= 0 && c > cc) return 3'b000;
      total = nb * BEEP + (nb - 1) * GAP;
      if (c == total + 1) return 3'b001;
      if (c > total) return 3'b000;
      pos = (c - 1) % (BEEP + GAP);
      if (pos < BEEP) return {(((pos / HALF) % 2) == 0), 1'b1, 1'b0};
      return 3'b010;
   endfunction

   // Entered just after a rising edge; cycle 0 is the trigger cycle.
   task automatic run_pattern(input string name, input int nb, input int model_nb,
                              input int cancel_c, input int retrig_c, input int nb2,
                              input bit cancel_with_trig, input int ncyc);
      logic [2:0] got;
      logic [2:0] exp;
      for (int k = 0; k <= ncyc; k++) begin
         trigger   = (k == 0) || (k == retrig_c);
         num_beeps = (k == retrig_c) ? 4'(nb2) : 4'(nb);
         cancel    = (k == cancel_c) || (cancel_with_trig && k == 0);
         exp_q.push_back(model(k, model_nb, cancel_c));
         @(negedge clk);
         got = {tone_out, busy, done};
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: tone/busy/done=%b required %b", name, k, got, exp);
         end
         @(posedge clk);
         #1;
      end
      trigger = 1'b0;
      cancel  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      trigger   = 1'b0;
      cancel    = 1'b0;
      num_beeps = 4'd0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({tone_out, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_state: tone/busy/done=%b required 000", {tone_out, busy, done});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_burst();
      trigger   = 1'b1;
      num_beeps = 4'd2;
      @(posedge clk);
      #1;
      trigger = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_tests++;
      if ({tone_out, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_mid_pre: tone/busy=%b required 11", {tone_out, busy});
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({tone_out, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_async: tone/busy/done=%b required 000", {tone_out, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_pattern("reset_mid_after", 0, 0, -1, -1, 0, 1'b0, 30);
   endtask

   task automatic test_two_beeps();
      run_pattern("two_beeps", 2, 2, -1, -1, 0, 1'b0, 24);
   endtask

   task automatic test_one_beep();
      run_pattern("one_beep", 1, 1, -1, -1, 0, 1'b0, 12);
   endtask

   task automatic test_zero_beeps();
      run_pattern("zero_beeps", 0, 0, -1, -1, 0, 1'b0, 50);
   endtask

   task automatic test_cancel_in_gap();
      run_pattern("cancel_gap", 3, 3, 10, -1, 0, 1'b0, 45);
   endtask

   task automatic test_cancel_in_tone();
      run_pattern("cancel_tone", 2, 2, 5, -1, 0, 1'b0, 25);
   endtask

   task automatic test_retrigger();
      run_pattern("retrigger", 2, 2, -1, 4, 5, 1'b0, 30);
   endtask

   task automatic test_trigger_cancel_idle();
      run_pattern("trig_cancel_idle", 3, 0, -1, -1, 0, 1'b1, 20);
   endtask

   task automatic test_max_beeps();
      run_pattern("max_beeps", 15, 15, -1, -1, 0, 1'b0, 180);
   endtask

   task automatic test_back_to_back();
      run_pattern("b2b_first", 1, 1, -1, -1, 0, 1'b0, 9);
      run_pattern("b2b_second", 2, 2, -1, -1, 0, 1'b0, 22);
   endtask

   initial begin
      test_reset();
      test_two_beeps();
      test_one_beep();
      test_zero_beeps();
      test_cancel_in_gap();
      test_cancel_in_tone();
      test_retrigger();
      test_trigger_cancel_idle();
      test_back_to_back();
      test_max_beeps();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
